// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one fifo write port between N_REQ producers.
// A grant lasts for up to MAX_BURST beats. The fifo write signals are driven from the owner.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]              req_last,
    output logic [N_REQ-1:0]              ack,
    output logic [N_REQ-1:0]              gnt,
    input  logic                          fifo_full,
    output logic                          fifo_we,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic [$clog2(N_REQ)-1:0]      fifo_wsrc
);

    localparam int unsigned ID_WIDTH = $clog2(N_REQ);
    localparam int unsigned CNT_W    = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   owner_q, owner_d;
    logic [ID_WIDTH-1:0]   rr_last_q, rr_last_d;
    logic [N_REQ-1:0]      gnt_q, gnt_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [ID_WIDTH-1:0]   sel_idx;
    logic                  sel_found;
    logic                  write;
    logic [DATA_WIDTH-1:0] beat [N_REQ];

    // Unpack the flat request data bus into one beat per requester
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign beat[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search starting just after the last granted requester
    always_comb begin
        int unsigned cand;
        cand      = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(rr_last_q) + k) % N_REQ;
            if (!sel_found && req[ID_WIDTH'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = ID_WIDTH'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_last_q  <= ID_WIDTH'(N_REQ - 1);
            gnt_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next-state and write-port decode; the write path is combinational from the owner
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        write      = 1'b0;
        ack        = '0;
        fifo_we    = 1'b0;
        fifo_wdata = '0;
        fifo_wsrc  = '0;

        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d    = ST_BURST;
                    owner_d    = sel_idx;
                    rr_last_d  = sel_idx;
                    gnt_d      = N_REQ'(1) << sel_idx;
                    beat_cnt_d = '0;
                end
            end
            ST_BURST: begin
                write     = req[owner_q] & ~fifo_full;
                fifo_wsrc = owner_q;
                if (write) begin
                    ack        = N_REQ'(1) << owner_q;
                    fifo_we    = 1'b1;
                    fifo_wdata = beat[owner_q];
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (req_last[owner_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                        state_d    = ST_IDLE;
                        gnt_d      = '0;
                        beat_cnt_d = '0;
                    end
                end else if (!req[owner_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign gnt = gnt_q;

endmodule
